// File: rtl/latch_pipe_skid_pkg.sv
// Shared definitions for the two-entry skid pipeline stage: state encoding
// and the bit positions of the control bundle.
package latch_pipe_skid_pkg;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int CTRL_ZERO       = 0;
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_JUMP       = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_BRANCH_NOT = 5;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 7;

endpackage

// File: rtl/latch_pipe_skid_slot.sv
// One load-enabled entry register. It clears on reset and otherwise holds its
// value until it is loaded.
module pipe_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/latch_pipe_skid.sv
// Pipeline register with a skid slot: in_ready is registered, so upstream
// never sees a combinational path from out_ready.
module latch_pipe_skid
  import latch_pipe_skid_pkg::*;
#(
  parameter int B      = 32,
  parameter int W      = 5,
  parameter int NW     = 3,
  parameter int CTRL_W = 8,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NW*B-1:0]   in_data,
  input  logic [W-1:0]      in_dst,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NW*B-1:0]   out_data,
  output logic [W-1:0]      out_dst,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OP_W-1:0]   out_op,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = NW*B + W + CTRL_W + OP_W;

  state_t state, state_nxt;
  logic   accept, drain;
  logic   load_main, load_skid, main_from_skid;
  logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;
  logic [CTRL_W-1:0]  main_ctrl;

  assign in_entry  = {in_data, in_dst, in_ctrl, in_op};
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        case ({accept, drain})
          2'b11: load_main = 1'b1;
          2'b10: begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end
          2'b01:   state_nxt = ST_EMPTY;
          default: state_nxt = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (drain) begin
          state_nxt      = ST_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush drops everything; slot contents stay so outputs keep their last value.
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  pipe_slot #(.WIDTH(ENTRY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.WIDTH(ENTRY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign {out_data, out_dst, main_ctrl, out_op} = main_q;
  // Bubbles never carry live control bits.
  assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule
